// File: rtl/alu_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_scheduler
// Description : Round-robin arbiter sharing one ALU/UART datapath between
//               N_REQ requesters, with per-operation completion timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_scheduler #(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [4*N_REQ-1:0]   req_a,
    input  logic [4*N_REQ-1:0]   req_b,
    input  logic [3*N_REQ-1:0]   req_opcode,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [2:0]           alu_opcode,
    output logic                 alu_start,
    input  logic                 alu_done,
    input  logic [15:0]          alu_result,
    input  logic                 uart_busy,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [15:0]          rsp_result,
    output logic                 rsp_error,
    output logic [1:0]           grant_id,
    output logic                 busy
);

    localparam logic [2:0] c_N_REQ   = 3'(N_REQ);
    localparam logic [8:0] c_TIMEOUT = 9'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    logic [1:0]         r_last_grant;
    logic [1:0]         r_grant_id;
    logic [7:0]         r_count;
    logic [3:0]         r_a;
    logic [3:0]         r_b;
    logic [2:0]         r_opcode;
    logic               r_alu_start;
    logic [N_REQ-1:0]   r_rsp_valid;
    logic [15:0]        r_rsp_result;
    logic               r_rsp_error;

    logic [2:0]         w_cand;
    logic [1:0]         w_sel;
    logic               w_sel_found;
    logic               w_accept;
    logic [3:0]         w_sel_a;
    logic [3:0]         w_sel_b;
    logic [2:0]         w_sel_opcode;
    logic [N_REQ-1:0]   w_grant_oh;
    logic [8:0]         w_count_next;
    logic               w_timeout;

    // Walk the requesters starting just above the last grant; the first
    // pending one at the smallest rotational offset wins.
    always_comb begin
        w_cand      = '0;
        w_sel       = '0;
        w_sel_found = 1'b0;
        for (int off = 1; off <= N_REQ; off++) begin
            w_cand = {1'b0, r_last_grant} + 3'(off);
            if (w_cand >= c_N_REQ) begin
                w_cand = w_cand - c_N_REQ;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (!w_sel_found && req_valid[i] && (w_cand == 3'(i))) begin
                    w_sel_found = 1'b1;
                    w_sel       = 2'(i);
                end
            end
        end
    end

    always_comb begin
        w_sel_a      = '0;
        w_sel_b      = '0;
        w_sel_opcode = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel == 2'(i)) begin
                w_sel_a      = req_a[4*i +: 4];
                w_sel_b      = req_b[4*i +: 4];
                w_sel_opcode = req_opcode[3*i +: 3];
            end
        end
    end

    assign w_accept = reset_n && (r_state == S_IDLE) && w_sel_found && !uart_busy;

    always_comb begin
        req_ready  = '0;
        w_grant_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i]  = w_accept && (w_sel == 2'(i));
            w_grant_oh[i] = (r_grant_id == 2'(i));
        end
    end

    assign w_count_next = {1'b0, r_count} + 9'd1;
    assign w_timeout    = (w_count_next == c_TIMEOUT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 2'(N_REQ - 1);
            r_grant_id   <= '0;
            r_count      <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_opcode     <= '0;
            r_alu_start  <= 1'b0;
            r_rsp_valid  <= '0;
            r_rsp_result <= '0;
            r_rsp_error  <= 1'b0;
        end else begin
            r_alu_start <= 1'b0;
            r_rsp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a         <= w_sel_a;
                        r_b         <= w_sel_b;
                        r_opcode    <= w_sel_opcode;
                        r_grant_id  <= w_sel;
                        r_alu_start <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_count <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion in the final counted cycle still wins.
                    if (alu_done) begin
                        r_rsp_result <= alu_result;
                        r_rsp_error  <= 1'b0;
                        r_rsp_valid  <= w_grant_oh;
                        r_state      <= S_RESP;
                    end else if (w_timeout) begin
                        r_rsp_result <= 16'h0000;
                        r_rsp_error  <= 1'b1;
                        r_rsp_valid  <= w_grant_oh;
                        r_state      <= S_RESP;
                    end else begin
                        r_count <= w_count_next[7:0];
                    end
                end
                S_RESP: begin
                    r_last_grant <= r_grant_id;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign alu_a      = {4'h0, r_a};
    assign alu_b      = {4'h0, r_b};
    assign alu_opcode = r_opcode;
    assign alu_start  = r_alu_start;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_error  = r_rsp_error;
    assign grant_id   = r_grant_id;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/alu_op_scheduler.md
# alu_op_scheduler

Round-robin scheduler that shares the single FSM/ALU/UART datapath between `N_REQ` independent requesters. Each requester submits a 4-bit operand pair and a 3-bit opcode. The scheduler picks one requester, drives the datapath, and waits for completion or a timeout. It then returns the 16-bit result to that requester alone. It sits between the top-level input decode and the `FSM` core instance, replacing the direct pin-to-core wiring.

## Interface
- `N_REQ`, 2: number of requesters; legal range 2–4.
- `TIMEOUT`, 255: maximum cycles spent in WAIT before aborting; legal range 1–255.
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  request pending, one bit per requester; held until accepted.
- `req_ready`  out  N_REQ  one-hot accept pulse, one cycle wide.
- `req_a`  in  4*N_REQ  operand A; requester i uses bits [4i+3:4i].
- `req_b`  in  4*N_REQ  operand B; same packing as `req_a`.
- `req_opcode`  in  3*N_REQ  opcode; requester i uses bits [3i+2:3i].
- `alu_a`, `alu_b`  out  8 each  latched operands, zero-extended ({4'b0, nibble}).
- `alu_opcode`  out  3  latched opcode.
- `alu_start`  out  1  one-cycle launch pulse to the core.
- `alu_done`  in  1  one-cycle completion pulse from the core.
- `alu_result`  in  16  core result; valid in the `alu_done` cycle.
- `uart_busy`  in  1  UART transmitter busy.
- `rsp_valid`  out  N_REQ  one-hot, one-cycle response pulse to the granted requester.
- `rsp_result`  out  16  response data; valid while any `rsp_valid` bit is high.
- `rsp_error`  out  1  high together with `rsp_valid` when the operation timed out.
- `grant_id`  out  2  index of the current or last granted requester.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States are IDLE, ISSUE, WAIT and RESP.
- IDLE:
  - Leave IDLE only when at least one `req_valid` bit is set and `uart_busy` is 0.
  - Grant selection is round-robin: search upward from `last_grant+1`, wrapping modulo N_REQ.
  - In the accepting cycle, drive `req_ready[g]`=1 (combinational from the state and the selection).
  - At the clock edge: latch that requester's operands and opcode, set `grant_id`=g, go to ISSUE.
- ISSUE:
  - `alu_start`=1 for exactly this cycle.
  - Clear the timeout counter.
  - Go to WAIT.
- WAIT:
  - On `alu_done`=1, capture `alu_result` into the response register, clear the error flag and go to RESP.
  - Otherwise increment the counter.
  - When the counter reaches TIMEOUT with no `alu_done`, set the response to 16'h0000 and the error flag to 1, then go to RESP.
  - `alu_done` takes priority over timeout when both occur in the same cycle.
- RESP:
  - `rsp_valid[grant_id]`=1 for one cycle; `rsp_result` and `rsp_error` carry the captured values.
  - Set `last_grant`=`grant_id`, then return to IDLE.
- Requesters that are not granted keep `req_valid` asserted and are not disturbed.
- A `req_valid` that drops before acceptance is simply not served.
- An `alu_done` received outside WAIT is ignored.
- `alu_a`, `alu_b` and `alu_opcode` stay stable from ISSUE until the next acceptance.

## Timing
- Values on reset (asynchronous, `reset_n`=0):
  - State = IDLE.
  - All outputs are 0: `req_ready`, `alu_start`, `alu_a`, `alu_b`, `alu_opcode`, `rsp_valid`, `rsp_result`, `rsp_error`, `grant_id`, `busy`.
  - `last_grant` = N_REQ-1, so requester 0 wins first.
  - Timeout counter = 0.
- Reset mid-operation aborts the in-flight operation. No response is issued for it.
- Latency:
  - Acceptance at cycle k gives `alu_start` at k+1.
  - `alu_done` at cycle d (d ≥ k+2) gives `rsp_valid` at d+1.
  - Minimum request-to-response latency is 3 cycles.
  - Timeout response arrives at k+2+TIMEOUT.
- Back-to-back operation: IDLE can accept again in the cycle after RESP. Maximum throughput is one operation per 4 cycles.
- `uart_busy` is sampled only in IDLE. Its changes during ISSUE, WAIT or RESP have no effect.
- At most one bit of `req_ready` is set per cycle, and at most one bit of `rsp_valid`.

## Test plan
- Reset, then requester 0 sends a=4'h3, b=4'h5, op=3'b000. The core model pulses `alu_done` 2 cycles after start with result 16'h0008. Required: `req_ready[0]` in cycle 0, `alu_a`=8'h03, `alu_b`=8'h05, `alu_start` in cycle 1, `rsp_valid[0]` with `rsp_result`=16'h0008 and `rsp_error`=0.
- With N_REQ=2, both requesters hold `req_valid` continuously. Required: grants alternate 0,1,0,1 over 4 operations, and each `rsp_valid` goes only to the granted index.
- `uart_busy`=1 while a request is pending. Required: `req_ready` stays 0 and `busy`=0. After `uart_busy` falls, acceptance occurs in that same cycle.
- The core never pulses `alu_done`, with TIMEOUT=4. Required: `rsp_valid` arrives 6 cycles after acceptance, with `rsp_error`=1 and `rsp_result`=16'h0000. The next request is then served normally.
- Drive `reset_n` low for 1 cycle while in WAIT. Required: all outputs are 0 immediately. A stray `alu_done` after reset produces no response. The next grant goes to requester 0.
- Pulse `alu_done` in the same cycle the timeout count is reached. Required: the real result is returned with `rsp_error`=0.
